// File: rtl/soc_wb_pkg.sv
// Shared types and constants for the Wishbone multi-master interconnect.
// Holds the FSM encoding, default bus widths and a width helper for grant indices.
package soc_wb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam int DEF_WB_DW = 32;
    localparam int DEF_WB_AW = 16;
    localparam int DEF_SEL_W = 4;

    // Bits needed to hold an index in 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/soc_wb_rr_arb.sv
// Combinational round-robin winner search.
// Scans req starting at ptr and wrapping around; the first set bit wins.
module soc_wb_rr_arb
    import soc_wb_pkg::*;
#(
    parameter int WB_M = 2,
    parameter int GW   = clog2_min1(WB_M)
) (
    input  logic [WB_M-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   gnt,
    output logic            any
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        any = 1'b0;
        for (int k = WB_M - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= WB_M) begin
                idx = idx - WB_M;
            end
            if (req[idx]) begin
                gnt = GW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_wb_arbiter.sv
// Multi-master Wishbone interconnect: round-robin arbitration, address decode,
// decode-error completion and a per-transaction timeout with sticky error flags.
module soc_wb_arbiter
    import soc_wb_pkg::*;
#(
    parameter int WB_M  = 2,
    parameter int WB_N  = 6,
    parameter int WB_DW = DEF_WB_DW,
    parameter int WB_AW = DEF_WB_AW,
    parameter int SEL_W = DEF_SEL_W,
    parameter int TO_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WB_M*WB_AW-1:0]     m_addr,
    input  logic [WB_M*WB_DW-1:0]     m_wdata,
    input  logic [WB_M*(WB_DW/8)-1:0] m_wmsk,
    input  logic [WB_M-1:0]           m_we,
    input  logic [WB_M-1:0]           m_cyc,
    output logic [WB_M*WB_DW-1:0]     m_rdata,
    output logic [WB_M-1:0]           m_ack,
    output logic [WB_AW-1:0]          s_addr,
    output logic [WB_DW-1:0]          s_wdata,
    output logic [WB_DW/8-1:0]        s_wmsk,
    output logic                      s_we,
    output logic [WB_N-1:0]           s_cyc,
    input  logic [WB_N*WB_DW-1:0]     s_rdata,
    input  logic [WB_N-1:0]           s_ack,
    output logic                      err,
    input  logic                      err_clr,
    output logic                      err_to
);

    localparam int GW = clog2_min1(WB_M);
    localparam int MW = WB_DW / 8;
    localparam logic [TO_W-1:0]  TO_MAX = '1;
    localparam logic [SEL_W:0]   N_LIM  = (SEL_W+1)'(WB_N);

    state_t            state_reg, state_next;
    logic [GW-1:0]     gnt_reg, gnt_next;
    logic [GW-1:0]     rr_reg, rr_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic              valid_reg, valid_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              err_reg, err_next;
    logic              err_to_reg, err_to_next;

    logic [GW-1:0]     arb_gnt;
    logic              arb_any;

    soc_wb_rr_arb #(
        .WB_M (WB_M),
        .GW   (GW)
    ) u_rr_arb (
        .req (m_cyc),
        .ptr (rr_reg),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // Winner's slave index (used in IDLE) and the granted master's bus (used in ACTIVE).
    logic [SEL_W-1:0]  win_sel;
    logic [WB_AW-1:0]  gm_addr;
    logic [WB_DW-1:0]  gm_wdata;
    logic [MW-1:0]     gm_wmsk;
    logic              gm_we;
    logic              gm_cyc;
    logic              slv_ack;
    logic [WB_DW-1:0]  slv_rdata;

    always_comb begin
        win_sel   = '0;
        gm_addr   = '0;
        gm_wdata  = '0;
        gm_wmsk   = '0;
        gm_we     = 1'b0;
        gm_cyc    = 1'b0;
        slv_ack   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < WB_M; i++) begin
            if (arb_gnt == GW'(i)) begin
                win_sel = m_addr[i*WB_AW + WB_AW - 1 -: SEL_W];
            end
            if (gnt_reg == GW'(i)) begin
                gm_addr  = m_addr[i*WB_AW +: WB_AW];
                gm_wdata = m_wdata[i*WB_DW +: WB_DW];
                gm_wmsk  = m_wmsk[i*MW +: MW];
                gm_we    = m_we[i];
                gm_cyc   = m_cyc[i];
            end
        end
        for (int j = 0; j < WB_N; j++) begin
            if (sel_reg == SEL_W'(j)) begin
                slv_ack   = s_ack[j];
                slv_rdata = s_rdata[j*WB_DW +: WB_DW];
            end
        end
    end

    logic ack_c;
    logic rd_pass_c;
    logic set_err_c;
    logic set_to_c;
    logic done_c;

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        sel_next    = sel_reg;
        valid_next  = valid_reg;
        rr_next     = rr_reg;
        to_cnt_next = to_cnt_reg;
        ack_c       = 1'b0;
        rd_pass_c   = 1'b0;
        set_err_c   = 1'b0;
        set_to_c    = 1'b0;
        done_c      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next  = ST_ACTIVE;
                    gnt_next    = arb_gnt;
                    sel_next    = win_sel;
                    valid_next  = ({1'b0, win_sel} < N_LIM);
                    to_cnt_next = '0;
                end
            end
            ST_ACTIVE: begin
                to_cnt_next = to_cnt_reg + TO_W'(1);
                // Abort beats decode error beats slave ack beats timeout.
                if (!gm_cyc) begin
                    done_c = 1'b1;
                end else if (!valid_reg) begin
                    done_c    = 1'b1;
                    ack_c     = 1'b1;
                    set_err_c = 1'b1;
                end else if (slv_ack) begin
                    done_c    = 1'b1;
                    ack_c     = 1'b1;
                    rd_pass_c = 1'b1;
                end else if (to_cnt_reg == TO_MAX) begin
                    done_c    = 1'b1;
                    ack_c     = 1'b1;
                    set_err_c = 1'b1;
                    set_to_c  = 1'b1;
                end
                if (done_c) begin
                    state_next = ST_IDLE;
                    rr_next    = (gnt_reg == GW'(WB_M - 1)) ? '0 : gnt_reg + GW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        err_next    = err_reg;
        err_to_next = err_to_reg;
        if (set_err_c) begin
            err_next    = 1'b1;
            err_to_next = set_to_c;
        end else if (err_clr) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            rr_reg     <= '0;
            sel_reg    <= '0;
            valid_reg  <= 1'b0;
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
            err_to_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            rr_reg     <= rr_next;
            sel_reg    <= sel_next;
            valid_reg  <= valid_next;
            to_cnt_reg <= to_cnt_next;
            err_reg    <= err_next;
            err_to_reg <= err_to_next;
        end
    end

    logic active;
    assign active = (state_reg == ST_ACTIVE);

    generate
        for (genvar gi = 0; gi < WB_N; gi++) begin : g_slv
            assign s_cyc[gi] = active && valid_reg && (sel_reg == SEL_W'(gi));
        end
        for (genvar gi = 0; gi < WB_M; gi++) begin : g_mst
            assign m_ack[gi] = ack_c && (gnt_reg == GW'(gi));
            assign m_rdata[gi*WB_DW +: WB_DW] =
                (rd_pass_c && (gnt_reg == GW'(gi))) ? slv_rdata : '0;
        end
    endgenerate

    assign s_addr  = active ? gm_addr  : '0;
    assign s_wdata = active ? gm_wdata : '0;
    assign s_wmsk  = active ? gm_wmsk  : '0;
    assign s_we    = active ? gm_we    : 1'b0;
    assign err     = err_reg;
    assign err_to  = err_to_reg;

endmodule

// File: tb/tb_soc_wb_arbiter.sv
// Self-checking bench for soc_wb_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level reference model.
module tb_soc_wb_arbiter;

    localparam int M    = 3;
    localparam int N    = 6;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int SW   = 4;
    localparam int TW   = 4;
    localparam int MW   = DW / 8;
    localparam int TMAX = (1 << TW) - 1;
    localparam int HANG = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [M*AW-1:0]   m_addr = '0;
    logic [M*DW-1:0]   m_wdata = '0;
    logic [M*MW-1:0]   m_wmsk = '0;
    logic [M-1:0]      m_we = '0;
    logic [M-1:0]      m_cyc = '0;
    logic [M*DW-1:0]   m_rdata;
    logic [M-1:0]      m_ack;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [MW-1:0]     s_wmsk;
    logic              s_we;
    logic [N-1:0]      s_cyc;
    logic [N*DW-1:0]   s_rdata = '0;
    logic [N-1:0]      s_ack = '0;
    logic              err;
    logic              err_clr = 1'b0;
    logic              err_to;

    soc_wb_arbiter #(
        .WB_M(M), .WB_N(N), .WB_DW(DW), .WB_AW(AW), .SEL_W(SW), .TO_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmsk(m_wmsk), .m_we(m_we), .m_cyc(m_cyc),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wmsk(s_wmsk), .s_we(s_we), .s_cyc(s_cyc),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .err(err), .err_clr(err_clr), .err_to(err_to)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Master request book and slave behaviour knobs
    logic            req_pend[M];
    logic [AW-1:0]   req_addr[M];
    logic            req_we[M];
    logic [DW-1:0]   req_wdata[M];
    logic [MW-1:0]   req_wmsk[M];
    logic [M-1:0]    keep_req = '0;
    logic [AW-1:0]   keep_addr[M];
    logic [DW-1:0]   slv_rd[N];
    int              slv_lat[N];
    int              abort_plan = -1;
    bit              rand_mode = 1'b0;
    bit              clr_force = 1'b0;

    // Transaction-level reference state
    bit  busy = 1'b0;
    int  cur_gnt, cur_sel, cur_idx, cur_lat, cur_abort;
    bit  cur_valid;
    int  ptr = 0;
    bit  err_m = 1'b0;
    bit  err_to_m = 1'b0;
    int  txn_no = 0;

    int  ack_q[$];
    int  t4_cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int m, input logic [AW-1:0] a);
        req_pend[m]  = 1'b1;
        req_addr[m]  = a;
        req_we[m]    = 1'($urandom_range(0, 1));
        req_wdata[m] = $urandom;
        req_wmsk[m]  = MW'($urandom_range(0, (1 << MW) - 1));
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int s;
        logic [AW-1:0] a;
        s = ($urandom_range(0, 9) < 8) ? $urandom_range(0, N - 1) : $urandom_range(N, (1 << SW) - 1);
        a = AW'($urandom_range(0, (1 << (AW - SW)) - 1));
        a[AW-1 -: SW] = SW'(s);
        return a;
    endfunction

    function automatic bit pend_any();
        bit r;
        r = 1'b0;
        for (int i = 0; i < M; i++) r = r | req_pend[i];
        return r;
    endfunction

    // One bus cycle: drive at negedge, check after settling, advance the model.
    task automatic cycle();
        int kind;
        int w;
        int r;
        bit found;
        logic [N-1:0]    exp_scyc;
        logic [M-1:0]    exp_ack;
        logic [M*DW-1:0] exp_rd;
        logic [AW+DW+MW:0] exp_bus;
        @(negedge clk);
        if (busy && cur_idx == cur_abort) req_pend[cur_gnt] = 1'b0;
        for (int i = 0; i < M; i++) begin
            m_cyc[i]              = req_pend[i];
            m_addr[i*AW +: AW]    = req_addr[i];
            m_we[i]               = req_we[i];
            m_wdata[i*DW +: DW]   = req_wdata[i];
            m_wmsk[i*MW +: MW]    = req_wmsk[i];
        end
        for (int j = 0; j < N; j++) begin
            if (rand_mode) slv_rd[j] = $urandom;
            s_rdata[j*DW +: DW] = slv_rd[j];
            s_ack[j] = 1'($urandom_range(0, 1));
        end
        if (busy && cur_valid) s_ack[cur_sel] = (cur_idx == cur_lat);
        err_clr = clr_force || (rand_mode && $urandom_range(0, 7) == 0);
        #1;
        // 0 none, 1 abort, 2 decode error, 3 slave ack, 4 timeout
        kind = 0;
        if (busy) begin
            if (!m_cyc[cur_gnt])        kind = 1;
            else if (!cur_valid)        kind = 2;
            else if (cur_idx == cur_lat) kind = 3;
            else if (cur_idx == TMAX)   kind = 4;
        end
        exp_scyc = '0;
        if (busy && cur_valid) exp_scyc[cur_sel] = 1'b1;
        exp_ack = '0;
        if (kind >= 2) exp_ack[cur_gnt] = 1'b1;
        exp_rd = '0;
        if (kind == 3) exp_rd[cur_gnt*DW +: DW] = slv_rd[cur_sel];
        exp_bus = '0;
        if (busy) exp_bus = {req_addr[cur_gnt], req_wdata[cur_gnt], req_wmsk[cur_gnt], req_we[cur_gnt]};
        chk("s_cyc", 128'(s_cyc), 128'(exp_scyc));
        chk("m_ack", 128'(m_ack), 128'(exp_ack));
        chk("m_rdata", 128'(m_rdata), 128'(exp_rd));
        chk("s_bus", 128'({s_addr, s_wdata, s_wmsk, s_we}), 128'(exp_bus));
        chk("err", 128'(err), 128'(err_m));
        chk("err_to", 128'(err_to), 128'(err_to_m));
        for (int i = 0; i < M; i++) if (m_ack[i]) ack_q.push_back(i);
        if (s_cyc[2] && m_ack == '0) t4_cnt++;

        if (kind == 2 || kind == 4) begin
            err_m    = 1'b1;
            err_to_m = (kind == 4);
        end else if (err_clr) begin
            err_m = 1'b0;
        end
        if (busy) begin
            if (kind != 0) begin
                txn_no++;
                $display("txn %0d: master %0d slave %0d %s after %0d active cycles", txn_no, cur_gnt,
                         cur_sel, (kind == 1) ? "abort" : (kind == 2) ? "decode-error" :
                         (kind == 3) ? "ack" : "timeout", cur_idx + 1);
                if (kind != 1) req_pend[cur_gnt] = 1'b0;
                busy = 1'b0;
                ptr  = (cur_gnt + 1) % M;
            end else begin
                cur_idx++;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < M; k++) begin
                w = (ptr + k) % M;
                if (!found && m_cyc[w]) begin
                    found   = 1'b1;
                    cur_gnt = w;
                end
            end
            if (found) begin
                busy      = 1'b1;
                cur_sel   = int'(req_addr[cur_gnt][AW-1 -: SW]);
                cur_valid = (cur_sel < N);
                cur_idx   = 0;
                if (rand_mode) begin
                    r = $urandom_range(0, 19);
                    cur_lat = (r < 14) ? $urandom_range(0, 3) : (r < 16) ? TMAX :
                              (r < 18) ? HANG : $urandom_range(4, TMAX - 1);
                    cur_abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
                end else begin
                    cur_lat   = cur_valid ? slv_lat[cur_sel] : 0;
                    cur_abort = abort_plan;
                end
                abort_plan = -1;
            end
        end
        for (int i = 0; i < M; i++) begin
            if (!req_pend[i]) begin
                if (keep_req[i]) new_req(i, keep_addr[i]);
                else if (rand_mode && $urandom_range(0, 2) == 0) new_req(i, rand_addr());
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || pend_any()) && n < 200) begin
            cycle();
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $error("FAIL drain observed=busy expected=idle within 200 cycles");
        end
    endtask

    task automatic model_reset();
        busy = 1'b0;
        ptr = 0;
        err_m = 1'b0;
        err_to_m = 1'b0;
        for (int i = 0; i < M; i++) req_pend[i] = 1'b0;
        m_cyc = '0;
    endtask

    initial begin
        for (int i = 0; i < M; i++) begin
            req_pend[i] = 1'b0; req_addr[i] = '0; req_we[i] = 1'b0;
            req_wdata[i] = '0; req_wmsk[i] = '0; keep_addr[i] = '0;
        end
        for (int j = 0; j < N; j++) begin
            slv_rd[j] = '0; slv_lat[j] = 0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_cyc", 128'(s_cyc), 128'(0));
        chk("rst_m_ack", 128'(m_ack), 128'(0));
        chk("rst_err", 128'({err, err_to}), 128'(0));
        chk("rst_bus", 128'({s_addr, s_wdata, s_wmsk, s_we, m_rdata}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // T1: master 0 reads slave 1 which acks immediately
        slv_rd[1] = 32'hDEADBEEF;
        slv_lat[1] = 0;
        new_req(0, 16'h1004);
        req_we[0] = 1'b0;
        ack_q.delete();
        run(3);
        chk("t1_acks", 128'(ack_q.size()), 128'(1));
        chk("t1_master", 128'((ack_q.size() > 0) ? ack_q[0] : -1), 128'(0));

        // T2: masters 0 and 1 request back to back; pointer starts at 1
        slv_lat[0] = 0;
        slv_lat[1] = 1;
        keep_addr[0] = 16'h0040;
        keep_addr[1] = 16'h1080;
        keep_req = 3'b011;
        new_req(0, keep_addr[0]);
        new_req(1, keep_addr[1]);
        ack_q.delete();
        for (int n = 0; n < 100 && ack_q.size() < 8; n++) cycle();
        keep_req = '0;
        chk("t2_acks", 128'(ack_q.size() >= 8), 128'(1));
        for (int k = 0; k < 8; k++)
            chk("t2_alternate", 128'((k < ack_q.size()) ? ack_q[k] : -1), 128'((k % 2 == 0) ? 1 : 0));
        drain();

        // T3: decode error on unmapped slave 7
        new_req(0, 16'h7000);
        run(3);
        chk("t3_err_flags", 128'({err, err_to}), 128'(2'b10));

        // T4: slave 2 hangs, timeout after 15 stalled cycles, then clear err
        slv_lat[2] = HANG;
        new_req(0, 16'h2010);
        t4_cnt = 0;
        run(20);
        chk("t4_stall_cycles", 128'(t4_cnt), 128'(15));
        chk("t4_err_flags", 128'({err, err_to}), 128'(2'b11));
        clr_force = 1'b1;
        cycle();
        clr_force = 1'b0;
        run(2);
        chk("t4_err_cleared", 128'(err), 128'(0));

        // T5: master 1 abandons a stalled access to slave 3, then a normal access
        slv_lat[3] = HANG;
        abort_plan = 2;
        new_req(1, 16'h3000);
        ack_q.delete();
        run(6);
        chk("t5_no_ack", 128'(ack_q.size()), 128'(0));
        slv_lat[0] = 1;
        new_req(1, 16'h0008);
        run(5);
        chk("t5_next_ack", 128'(ack_q.size()), 128'(1));

        // T6: set err, start a stalled access, reset mid-transaction
        new_req(2, 16'hF000);
        run(3);
        new_req(1, 16'h3004);
        run(4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_cyc", 128'(s_cyc), 128'(0));
        chk("t6_rst_m_ack", 128'(m_ack), 128'(0));
        chk("t6_rst_err", 128'(err), 128'(0));
        chk("t6_rst_s_addr", 128'(s_addr), 128'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slv_lat[0] = 0;
        slv_lat[1] = 0;
        new_req(0, 16'h0100);
        new_req(1, 16'h1100);
        ack_q.delete();
        run(6);
        chk("t6_first_gnt", 128'((ack_q.size() > 0) ? ack_q[0] : -1), 128'(0));
        drain();

        // Random traffic
        rand_mode = 1'b1;
        run(2000);
        rand_mode = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
